// File: rtl/hq_pkg.sv
// Shared HaveQuick TOD framer types: FSM states, field lengths, flag positions, payload layout.
// Pure declarations: no latency.
// No flow control of its own.
package hq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        PAYLOAD,
        CHECK
    } hq_state_t;

    localparam int SYNC_LEN  = 16;
    localparam int PAY_LEN   = 40;
    localparam int CHK_LEN   = 8;
    localparam int FRAME_LEN = SYNC_LEN + PAY_LEN + CHK_LEN;

    localparam int FLAG_LOCK = 0;
    localparam int FLAG_LEAP = 1;
    localparam int FLAG_HOLD = 2;
    localparam int FLAG_BAD  = 3;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hEB90;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
        logic [3:0] doy_hi;
        logic [7:0] doy_lo;
        logic [3:0] flags;
    } hq_payload_t;

    function automatic logic bcd_bad(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    // Byte-wise sum mod 256 over the 40-bit payload.
    function automatic logic [7:0] hq_checksum(input hq_payload_t p);
        logic [39:0] v;
        v = p;
        return v[39:32] + v[31:24] + v[23:16] + v[15:8] + v[7:0];
    endfunction

endpackage

// File: rtl/hq_bit_timer.sv
// Bit-period divider: bit_tick on the last cycle of each BIT_DIV period, half_tick at mid-bit.
// Ticks are combinational from the count; start restarts the period at the next edge.
// No backpressure: free-runs while run is high, held at zero otherwise.
module hq_bit_timer #(
    parameter int BIT_DIV = 6250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic bit_tick,
    output logic half_tick
);

    localparam int CW = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start || !run) begin
            cnt <= '0;
        end else if (cnt == CW'(BIT_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick  = run && (cnt == CW'(BIT_DIV - 1));
    assign half_tick = run && (cnt == CW'(BIT_DIV / 2 - 1));

endmodule

// File: rtl/hq_tod_framer.sv
// HaveQuick TOD framer: snapshots BCD time fields, sends SYNC|payload|checksum (64 bits) MSB first; HQ_MANCHESTER_EN selects Manchester line coding.
// Latency: first bit on the line one edge after load_i; frame lasts 64*BIT_DIV cycles, done_o pulses at the end.
// No stall: load_i while a frame is active is dropped and flagged on overrun_o the next cycle.
module hq_tod_framer
    import hq_pkg::*;
#(
    parameter int          BIT_DIV   = 6250,
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] hour_bcd_i,
    input  logic [7:0] min_bcd_i,
    input  logic [7:0] sec_bcd_i,
    input  logic [3:0] doy_hi_bcd_i,
    input  logic [7:0] doy_lo_bcd_i,
    input  logic [2:0] flags_i,
    output logic       hq_data_o,
    output logic       hq_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       overrun_o
);

`ifdef HQ_MANCHESTER_EN
    localparam logic MANCH = 1'b1;
`else
    localparam logic MANCH = 1'b0;
`endif

    hq_state_t       state;
    logic [5:0]      bcnt;
    logic [63:0]     sr;
    hq_payload_t     pay;
    logic            bad_digit;
    logic [63:0]     frame;
    logic            start;
    logic            bit_tick;
    logic            half_tick;

    always_comb begin
        bad_digit = bcd_bad(hour_bcd_i) || bcd_bad(min_bcd_i) || bcd_bad(sec_bcd_i) ||
                    (doy_hi_bcd_i > 4'd9) || bcd_bad(doy_lo_bcd_i);
        pay.hour   = hour_bcd_i;
        pay.min    = min_bcd_i;
        pay.sec    = sec_bcd_i;
        pay.doy_hi = doy_hi_bcd_i;
        pay.doy_lo = doy_lo_bcd_i;
        pay.flags  = {bad_digit, flags_i};
        frame      = {SYNC_WORD, pay, hq_checksum(pay)};
    end

    assign start = (state == IDLE) && load_i;

    hq_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .run       (busy_o),
        .bit_tick  (bit_tick),
        .half_tick (half_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcnt      <= '0;
            sr        <= '0;
            hq_data_o <= 1'b0;
            hq_en_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
            if (state == IDLE) begin
                if (load_i) begin
                    state     <= SYNC;
                    bcnt      <= '0;
                    sr        <= frame;
                    hq_data_o <= frame[63];
                    hq_en_o   <= 1'b1;
                    busy_o    <= 1'b1;
                end
            end else begin
                // The final bit edge still counts as busy, so a load there is dropped too.
                overrun_o <= load_i;
                if (bit_tick) begin
                    if (bcnt == 6'(FRAME_LEN - 1)) begin
                        state     <= IDLE;
                        hq_data_o <= 1'b0;
                        hq_en_o   <= 1'b0;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                    end else begin
                        bcnt      <= bcnt + 1'b1;
                        sr        <= {sr[62:0], 1'b0};
                        hq_data_o <= sr[62];
                        if (bcnt == 6'(SYNC_LEN - 1)) begin
                            state <= PAYLOAD;
                        end else if (bcnt == 6'(SYNC_LEN + PAY_LEN - 1)) begin
                            state <= CHECK;
                        end
                    end
                end else if (half_tick) begin
                    // Second half of the bit: inverted for Manchester, unchanged for NRZ.
                    hq_data_o <= sr[63] ^ MANCH;
                end
            end
        end
    end

endmodule
